// File: rtl/pipe_sequencer_if.sv
// Control bundle between the pipeline sequencer and the datapath:
// the run/step inputs, the port-A arbitration inputs, the stage enables and the counters.
interface pipe_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             pause;
  logic             step_down;
  logic             wb_regwrite;
  logic             id_reads_a;
  logic             front_en;
  logic             idex_en;
  logic             idex_bubble;
  logic             back_en;
  logic             porta_write;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output pause, step_down, wb_regwrite, id_reads_a,
    input  front_en, idex_en, idex_bubble, back_en, porta_write,
    input  state, cycle_cnt, stall_cnt
  );

  modport slave (
    input  pause, step_down, wb_regwrite, id_reads_a,
    output front_en, idex_en, idex_bubble, back_en, porta_write,
    output state, cycle_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_sequencer.sv
// Run/step controller for the 5-stage pipeline, plus arbitration of register-file port A
// between a writeback write and an ID rs read.
module pipe_sequencer #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    PAUSED = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10
  } state_t;

  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES - 1);

  state_t           r_state;
  logic             r_sync1;
  logic             r_pause_s;
  logic [7:0]       r_step_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_active;
  logic             w_conflict;

  // PAUSE is a raw switch; both flops come out of reset in the halted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_pause_s <= 1'b1;
    end else begin
      r_sync1   <= bus.pause;
      r_pause_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PAUSED;
      r_step_cnt <= 8'd0;
    end else begin
      case (r_state)
        PAUSED: begin
          if (!r_pause_s) begin
            r_state <= RUN;
          end else if (bus.step_down) begin
            r_state    <= STEP;
            r_step_cnt <= STEP_LOAD;
          end
        end
        RUN: begin
          if (r_pause_s) r_state <= PAUSED;
        end
        STEP: begin
          // Releasing PAUSE mid-step drops whatever step budget is left.
          if (!r_pause_s) begin
            r_state    <= RUN;
            r_step_cnt <= 8'd0;
          end else if (r_step_cnt == 8'd0) begin
            r_state <= PAUSED;
          end else begin
            r_step_cnt <= r_step_cnt - 8'd1;
          end
        end
        default: r_state <= PAUSED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_active)   r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_conflict) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign w_active   = (r_state == RUN) || (r_state == STEP);
  assign w_conflict = w_active & bus.wb_regwrite & bus.id_reads_a;

  // On a conflict the write wins port A, ID is held and a NOP goes into EX.
  assign bus.back_en     = w_active;
  assign bus.porta_write = w_active & bus.wb_regwrite;
  assign bus.front_en    = w_active & ~w_conflict;
  assign bus.idex_en     = w_active;
  assign bus.idex_bubble = w_conflict;
  assign bus.state       = r_state;
  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench: two sequencers (STEP_CYCLES=1/CNT_W=16 and STEP_CYCLES=3/CNT_W=4)
// driven by the same inputs, with hand-computed expectations.
module tb_pipe_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b1;
  logic stepDown = 1'b0;
  logic wbRegwrite = 1'b0;
  logic idReadsA = 1'b0;
  int   nVec = 0;
  int   nErr = 0;
  int   actA;
  int   actB;

  always #5 clk = ~clk;

  pipe_sequencer_if #(.CNT_W(16)) busA ();
  pipe_sequencer_if #(.CNT_W(4))  busB ();

  assign busA.pause       = pause;
  assign busA.step_down   = stepDown;
  assign busA.wb_regwrite = wbRegwrite;
  assign busA.id_reads_a  = idReadsA;
  assign busB.pause       = pause;
  assign busB.step_down   = stepDown;
  assign busB.wb_regwrite = wbRegwrite;
  assign busB.id_reads_a  = idReadsA;

  pipe_sequencer #(.STEP_CYCLES(1), .CNT_W(16)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  pipe_sequencer #(.STEP_CYCLES(3), .CNT_W(4)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] ensA();
    return {busA.front_en, busA.idex_en, busA.idex_bubble, busA.back_en, busA.porta_write};
  endfunction

  function automatic logic [4:0] ensB();
    return {busB.front_en, busB.idex_en, busB.idex_bubble, busB.back_en, busB.porta_write};
  endfunction

  initial begin
    // Reset held: everything idle and cleared.
    applyStimulus(2);
    checkOutput("rst_ensA", 32'(ensA()), 32'h0);
    checkOutput("rst_ensB", 32'(ensB()), 32'h0);
    checkOutput("rst_stateA", 32'(busA.state), 32'h0);
    checkOutput("rst_cycA", 32'(busA.cycle_cnt), 32'h0);
    checkOutput("rst_stallA", 32'(busA.stall_cnt), 32'h0);
    rst = 1'b0;

    // Paused for 20 cycles: nothing moves.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      checkOutput("paused_stateA", 32'(busA.state), 32'h0);
      checkOutput("paused_ensA", 32'(ensA()), 32'h0);
      checkOutput("paused_cycA", 32'(busA.cycle_cnt), 32'h0);
    end

    // Single step press: A active 1 cycle, B active 3 cycles.
    stepDown = 1'b1;
    applyStimulus(1);
    stepDown = 1'b0;
    #1;
    checkOutput("step_stateA", 32'(busA.state), 32'h2);
    checkOutput("step_stateB", 32'(busB.state), 32'h2);
    checkOutput("step_ensA", 32'(ensA()), 32'h1A);
    actA = 0;
    actB = 0;
    for (int k = 0; k < 6; k++) begin
      actA += int'(busA.back_en);
      actB += int'(busB.back_en);
      applyStimulus(1);
    end
    checkOutput("step1_activeA", 32'(actA), 32'd1);
    checkOutput("step3_activeB", 32'(actB), 32'd3);
    checkOutput("step_endStateA", 32'(busA.state), 32'h0);
    checkOutput("step_endStateB", 32'(busB.state), 32'h0);
    checkOutput("step_cycA", 32'(busA.cycle_cnt), 32'd1);
    checkOutput("step_cycB", 32'(busB.cycle_cnt), 32'd3);

    // Paused writeback request never reaches port A.
    wbRegwrite = 1'b1;
    #1;
    checkOutput("paused_portaA", 32'(busA.porta_write), 32'h0);
    checkOutput("paused_portaB", 32'(busB.porta_write), 32'h0);
    wbRegwrite = 1'b0;

    // Second press overlaps the step window and must be ignored.
    stepDown = 1'b1;
    applyStimulus(1);
    actA = int'(busA.back_en);
    actB = int'(busB.back_en);
    applyStimulus(1);
    stepDown = 1'b0;
    for (int k = 0; k < 6; k++) begin
      actA += int'(busA.back_en);
      actB += int'(busB.back_en);
      applyStimulus(1);
    end
    checkOutput("ignPress_activeA", 32'(actA), 32'd1);
    checkOutput("ignPress_activeB", 32'(actB), 32'd3);
    checkOutput("ignPress_stateB", 32'(busB.state), 32'h0);
    checkOutput("ignPress_cycA", 32'(busA.cycle_cnt), 32'd2);
    checkOutput("ignPress_cycB", 32'(busB.cycle_cnt), 32'd6);

    // Reset in the middle of a step takes effect immediately.
    stepDown = 1'b1;
    applyStimulus(1);
    stepDown = 1'b0;
    #1;
    checkOutput("preRst_stateB", 32'(busB.state), 32'h2);
    checkOutput("preRst_ensB", 32'(ensB()), 32'h1A);
    rst = 1'b1;
    #1;
    checkOutput("midRst_ensA", 32'(ensA()), 32'h0);
    checkOutput("midRst_ensB", 32'(ensB()), 32'h0);
    checkOutput("midRst_stateB", 32'(busB.state), 32'h0);
    checkOutput("midRst_cycA", 32'(busA.cycle_cnt), 32'h0);
    checkOutput("midRst_cycB", 32'(busB.cycle_cnt), 32'h0);
    applyStimulus(1);
    rst = 1'b0;

    // Release PAUSE: RUN appears only after the third edge.
    pause = 1'b0;
    applyStimulus(1);
    checkOutput("run_E1_stateA", 32'(busA.state), 32'h0);
    applyStimulus(1);
    checkOutput("run_E2_stateA", 32'(busA.state), 32'h0);
    checkOutput("run_E2_ensA", 32'(ensA()), 32'h0);
    applyStimulus(1);
    checkOutput("run_E3_stateA", 32'(busA.state), 32'h1);
    checkOutput("run_E3_stateB", 32'(busB.state), 32'h1);
    checkOutput("run_E3_ensA", 32'(ensA()), 32'h1A);
    checkOutput("run_E3_cycA", 32'(busA.cycle_cnt), 32'd0);

    // Two consecutive port-A conflicts, then a write with no rs read.
    wbRegwrite = 1'b1;
    idReadsA = 1'b1;
    #1;
    checkOutput("conf1_ensA", 32'(ensA()), 32'h0F);
    applyStimulus(1);
    checkOutput("conf2_ensA", 32'(ensA()), 32'h0F);
    checkOutput("conf2_ensB", 32'(ensB()), 32'h0F);
    checkOutput("conf1_stallA", 32'(busA.stall_cnt), 32'd1);
    applyStimulus(1);
    checkOutput("conf_stallA", 32'(busA.stall_cnt), 32'd2);
    checkOutput("conf_cycA", 32'(busA.cycle_cnt), 32'd2);
    idReadsA = 1'b0;
    #1;
    checkOutput("noConf_ensA", 32'(ensA()), 32'h1B);
    applyStimulus(1);
    checkOutput("noConf_stallA", 32'(busA.stall_cnt), 32'd2);
    checkOutput("noConf_cycA", 32'(busA.cycle_cnt), 32'd3);
    wbRegwrite = 1'b0;

    // 17 active cycles in total: the 4-bit counter wraps to 1.
    applyStimulus(14);
    checkOutput("wrap_cycA", 32'(busA.cycle_cnt), 32'd17);
    checkOutput("wrap_cycB", 32'(busB.cycle_cnt), 32'd1);
    checkOutput("wrap_stallB", 32'(busB.stall_cnt), 32'd2);

    // Re-assert PAUSE: RUN persists for two edges, then the counters freeze.
    pause = 1'b1;
    applyStimulus(1);
    checkOutput("halt_E1_stateA", 32'(busA.state), 32'h1);
    checkOutput("halt_E1_cycA", 32'(busA.cycle_cnt), 32'd18);
    applyStimulus(1);
    checkOutput("halt_E2_stateA", 32'(busA.state), 32'h1);
    applyStimulus(1);
    checkOutput("halt_E3_stateA", 32'(busA.state), 32'h0);
    checkOutput("halt_E3_ensA", 32'(ensA()), 32'h0);
    checkOutput("halt_E3_cycA", 32'(busA.cycle_cnt), 32'd20);
    checkOutput("halt_E3_cycB", 32'(busB.cycle_cnt), 32'd4);
    applyStimulus(3);
    checkOutput("frozen_cycA", 32'(busA.cycle_cnt), 32'd20);
    checkOutput("frozen_cycB", 32'(busB.cycle_cnt), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Run/step controller and register-file port-A arbiter for the 5-stage 16-bit pipeline. It turns the PAUSE switch and the debounced STEP pulse into pipeline-register enables. It also resolves the port-A conflict on the 16x8 register file, where a writeback write and an ID rs read cannot share one cycle: it stalls the front end and inserts a bubble into ID/EX. It sits at top level beside the debouncer and drives the enable inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- STEP_CYCLES, default 1: active clock cycles granted per STEP press; legal range 1..255.
- CNT_W, default 16: width of the performance counters.

Ports:
- CLK  in  1  system clock (100 MHz); single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- PAUSE  in  1  raw switch level, asynchronous; 1 = halt free-run.
- step_down  in  1  one-cycle pulse from the debouncer btn_down output, already synchronous to CLK.
- wb_regwrite  in  1  WB stage wants to write the register file this cycle (MEM/WB regwrite).
- id_reads_a  in  1  the instruction in IF/ID reads rs through port A.
- front_en  out  1  enable for PC and IF/ID.
- idex_en  out  1  enable for ID/EX.
- idex_bubble  out  1  when 1, ID/EX loads all-zero controls (NOP) instead of decoded controls.
- back_en  out  1  enable for EX/MEM and MEM/WB.
- porta_write  out  1  port A owned by writeback; it selects the write address and gates wea.
- state  out  2  00 PAUSED, 01 RUN, 10 STEP.
- cycle_cnt  out  CNT_W  number of active cycles.
- stall_cnt  out  CNT_W  number of port-conflict stall cycles.

## Operation
- PAUSE passes through a 2-flop synchronizer; both flops reset to 1. The second flop is pause_s.
- active = (state == RUN) or (state == STEP).
- State machine (registered):
  - PAUSED: if pause_s = 0, go to RUN. Otherwise, if step_down = 1, go to STEP and load step_cnt = STEP_CYCLES-1.
  - RUN: if pause_s = 1, go to PAUSED. step_down is ignored.
  - STEP: if pause_s = 0, go to RUN and discard the remaining step cycles. Otherwise, if step_cnt = 0, go to PAUSED. Otherwise decrement step_cnt. step_down is ignored in STEP; presses are not queued.
- conflict = active & wb_regwrite & id_reads_a.
- Outputs, combinational from the registered state and the current inputs:
  - back_en = active.
  - porta_write = active & wb_regwrite. There is no write while PAUSED, so a frozen WB stage never rewrites.
  - front_en = active & ~conflict.
  - idex_en = active.
  - idex_bubble = conflict.
- Consequence of a conflict cycle: the write completes, the instruction in ID is held and re-reads port A next cycle, and a NOP enters EX. A conflict that persists over consecutive cycles repeats the stall each cycle.
- Stall cycles inside STEP consume step cycles.
- Counters:
  - cycle_cnt increments on each clock edge where active = 1.
  - stall_cnt increments on each clock edge where conflict = 1.
  - Both wrap modulo 2^CNT_W and are not saturating.

## Timing
- Reset values while RST is high: state = PAUSED, sync flops = 1, step_cnt = 0, both counters = 0. All enables, idex_bubble and porta_write are therefore 0.
- Reset mid-STEP or mid-RUN is immediate. The first transition out of PAUSED can happen only after two edges have synchronized PAUSE = 0.
- PAUSE change latency: if PAUSE changes before edge E1, pause_s updates at E2 and state updates at E3. The enables follow state in the cycle after E3.
- Step latency: with step_down high before edge E, state = STEP after E. Exactly STEP_CYCLES cycles follow with back_en = 1, then state returns to PAUSED.
- Simultaneous events:
  - step_down with pause_s = 0 in PAUSED: RUN wins.
  - RST has priority over everything.
- All outputs are valid in the same cycle as their inputs. There is no extra pipeline register on the enables.

## Test plan
- Reset then PAUSE = 1: state = 00, all enables 0, cycle_cnt = 0 for 20 cycles.
- PAUSE = 1, one step_down pulse, STEP_CYCLES = 1: back_en = 1 for exactly one cycle, then state = 00 and cycle_cnt = 1. Repeat with STEP_CYCLES = 3: back_en high for 3 cycles and cycle_cnt = 3.
- PAUSE 1→0 before edge E1: state = 01 after E3 and enables high in the next cycle. PAUSE 0→1 mid-run: state = 00 after 3 edges and cycle_cnt frozen.
- RUN with wb_regwrite = 1 and id_reads_a = 1 for 2 cycles: front_en = 0, idex_bubble = 1 and porta_write = 1 in both cycles, back_en = 1, stall_cnt = 2. Set wb_regwrite = 1 with id_reads_a = 0: no stall.
- PAUSED with wb_regwrite = 1: porta_write = 0. A step_down pulse during STEP is ignored, confirmed by STEP_CYCLES = 3 still giving exactly 3 active cycles.
- CNT_W = 4, RUN for 17 cycles: cycle_cnt wraps to 1. Assert RST mid-STEP: all outputs 0 in the same cycle and counters cleared.
